wb_port_arbiter: RTL and testbench

//  Arbitrates the single register-file write port between the in-order pipeline (ALU, load, link

---
 rtl/wb_port_arbiter_pkg.sv | 21 ++
 rtl/wb_port_arbiter_if.sv | 43 ++++
 rtl/wb_starve_ctr.sv | 33 +++
 rtl/wb_port_arbiter.sv | 139 +++++++++++++
 tb/tb_wb_port_arbiter.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the register-file writeback port arbiter:
// writeback source codes and the arbiter state encoding.
package wb_port_arbiter_pkg;

  localparam logic [1:0] WB_SRC_ALU  = 2'b00;
  localparam logic [1:0] WB_SRC_LOAD = 2'b01;
  localparam logic [1:0] WB_SRC_MD   = 2'b10;
  localparam logic [1:0] WB_SRC_LINK = 2'b11;

  typedef enum logic [1:0] {
    ST_ARB   = 2'b00,
    ST_FORCE = 2'b01,
    ST_HOLD  = 2'b10
  } arb_state_t;

  // The code 10 belongs to mul/div; the pipeline may never request it.
  function automatic logic pipe_src_legal(input logic [1:0] src);
    return (src != WB_SRC_MD);
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle of pipeline request, mul/div handshake and register-file write
// signals around the writeback port arbiter.
interface wb_port_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              pipe_valid;
  logic              pipe_we;
  logic [1:0]        pipe_src;
  logic [REG_AW-1:0] pipe_rd;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] link_pc;
  logic              md_valid;
  logic [REG_AW-1:0] md_rd;
  logic [DATA_W-1:0] md_res;
  logic              md_ready;
  logic              wb_stall;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [1:0]        wb_sel;
  logic              illegal_src;

  // Arbiter side: consumes requests, produces grants and the write port.
  modport slave (
    input  pipe_valid, pipe_we, pipe_src, pipe_rd,
    input  alu_res, load_data, link_pc,
    input  md_valid, md_rd, md_res,
    output md_ready, wb_stall,
    output rf_we, rf_waddr, rf_wdata, wb_sel, illegal_src
  );

  // Requester/environment side.
  modport master (
    output pipe_valid, pipe_we, pipe_src, pipe_rd,
    output alu_res, load_data, link_pc,
    output md_valid, md_rd, md_res,
    input  md_ready, wb_stall,
    input  rf_we, rf_waddr, rf_wdata, wb_sel, illegal_src
  );

endinterface

// File: rtl/wb_starve_ctr.sv
// Saturating wait counter for a pending mul/div result. hit flags the cycle
// whose wait brings the count to the limit, so the arbiter can switch to the
// forced state on the same edge the counter reaches it.
module wb_starve_ctr #(
  parameter int CNT_W = 3,
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  localparam logic [CNT_W-1:0] LIM    = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] LIM_M1 = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt;

  assign hit = inc && (cnt >= LIM_M1);

  // Count waiting cycles, saturate at the limit, clear on grant or idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LIM)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter between the in-order pipeline (MEM/WB)
// and the multi-cycle mul/div unit. The pipeline has priority; a mul/div
// result that has waited STARVE_LIMIT cycles forces a one-cycle stall.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int REG_AW       = 5,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  wb_port_arbiter_if.slave bus
);

  arb_state_t        state;
  logic              pipe_req;
  logic              illegal_req;
  logic              md_ready;
  logic              wb_stall;
  logic              md_hs;
  logic              md_wait;
  logic              pipe_grant;
  logic              grant_any;
  logic              starve_hit;
  logic [1:0]        sel_nxt;
  logic              we_nxt;
  logic [REG_AW-1:0] addr_nxt;
  logic [DATA_W-1:0] data_nxt;

  // Standard 4:1 writeback select mux.
  function automatic logic [DATA_W-1:0] wb_mux(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] alu,
    input logic [DATA_W-1:0] load,
    input logic [DATA_W-1:0] md,
    input logic [DATA_W-1:0] link
  );
    case (sel)
      WB_SRC_ALU:  return alu;
      WB_SRC_LOAD: return load;
      WB_SRC_MD:   return md;
      default:     return link;
    endcase
  endfunction

  // Request decode and the combinational grant/stall for this cycle.
  always_comb begin
    pipe_req    = bus.pipe_valid & bus.pipe_we & pipe_src_legal(bus.pipe_src);
    illegal_req = bus.pipe_valid & bus.pipe_we & ~pipe_src_legal(bus.pipe_src);
    md_ready    = 1'b0;
    wb_stall    = 1'b0;
    case (state)
      ST_ARB: begin
        md_ready = bus.md_valid & ~pipe_req;
      end
      ST_FORCE: begin
        md_ready = bus.md_valid;
        // Only stall when mul/div actually takes the port this cycle.
        wb_stall = pipe_req & bus.md_valid;
      end
      default: begin
        md_ready = 1'b0;
      end
    endcase
  end

  assign bus.md_ready = md_ready;
  assign bus.wb_stall = wb_stall;

  assign md_hs      = bus.md_valid & md_ready;
  assign md_wait    = bus.md_valid & ~md_ready;
  assign pipe_grant = pipe_req & ~md_hs;
  assign grant_any  = md_hs | pipe_grant;

  // Next-cycle write contents selected from the granted source.
  always_comb begin
    sel_nxt  = WB_SRC_ALU;
    addr_nxt = '0;
    if (md_hs) begin
      sel_nxt  = WB_SRC_MD;
      addr_nxt = bus.md_rd;
    end else if (pipe_grant) begin
      sel_nxt  = bus.pipe_src;
      addr_nxt = bus.pipe_rd;
    end
    data_nxt = grant_any ? wb_mux(sel_nxt, bus.alu_res, bus.load_data,
                                  bus.md_res, bus.link_pc) : '0;
    // Writes to r0 still consume the grant but never reach the register file.
    we_nxt   = grant_any & (addr_nxt != '0);
  end

  wb_starve_ctr #(
    .CNT_W (CNT_W),
    .LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (md_wait),
    .clr   (md_hs | ~bus.md_valid),
    .hit   (starve_hit)
  );

  // Arbitration FSM plus the registered write-port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_ARB;
      bus.rf_we       <= 1'b0;
      bus.rf_waddr    <= '0;
      bus.rf_wdata    <= '0;
      bus.wb_sel      <= WB_SRC_ALU;
      bus.illegal_src <= 1'b0;
    end else begin
      case (state)
        ST_ARB: begin
          if (starve_hit) state <= ST_FORCE;
        end
        ST_FORCE: begin
          if (md_hs)              state <= ST_HOLD;
          else if (!bus.md_valid) state <= ST_ARB;
        end
        ST_HOLD: begin
          // One guaranteed pipeline cycle so forcing can never repeat back-to-back.
          state <= ST_ARB;
        end
        default: begin
          state <= ST_ARB;
        end
      endcase
      bus.rf_we       <= we_nxt;
      bus.rf_waddr    <= addr_nxt;
      bus.rf_wdata    <= data_nxt;
      bus.wb_sel      <= sel_nxt;
      bus.illegal_src <= illegal_req;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for the writeback port arbiter.
module tb_wb_port_arbiter;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  wb_port_arbiter_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

  wb_port_arbiter #(
    .DATA_W       (DATA_W),
    .REG_AW       (REG_AW),
    .STARVE_LIMIT (4),
    .CNT_W        (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pipe(input logic v, input logic we, input logic [1:0] src,
                          input logic [REG_AW-1:0] rd);
    bus.pipe_valid = v;
    bus.pipe_we    = we;
    bus.pipe_src   = src;
    bus.pipe_rd    = rd;
  endtask

  task automatic set_md(input logic v, input logic [REG_AW-1:0] rd, input logic [DATA_W-1:0] res);
    bus.md_valid = v;
    bus.md_rd    = rd;
    bus.md_res   = res;
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [REG_AW-1:0] a,
                        input logic [DATA_W-1:0] d, input logic [1:0] sel);
    chk({tag, ".we"},   bus.rf_we,    we);
    chk({tag, ".addr"}, bus.rf_waddr, a);
    chk({tag, ".data"}, bus.rf_wdata, d);
    chk({tag, ".sel"},  bus.wb_sel,   sel);
  endtask

  task automatic chk_comb(input string tag, input logic rdy, input logic stall);
    #1;
    chk({tag, ".md_ready"}, bus.md_ready, rdy);
    chk({tag, ".wb_stall"}, bus.wb_stall, stall);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    set_pipe(0, 0, 2'b00, 0);
    set_md(0, 0, 0);
    bus.alu_res   = 32'h0000_1111;
    bus.load_data = 32'hDEAD_BEEF;
    bus.link_pc   = 32'h0000_2222;
    repeat (2) @(posedge clk);
    #1;
    chk_wr("rst0", 0, 0, 0, 2'b00);
    chk("rst0.illegal", bus.illegal_src, 0);
    chk_comb("rst0", 0, 0);
    rst_n = 1'b1;

    // Pipeline-only writes from each source.
    set_pipe(1, 1, 2'b01, 7);
    chk_comb("pipe_load", 0, 0);
    tick();
    chk_wr("pipe_load", 1, 7, 32'hDEAD_BEEF, 2'b01);
    set_pipe(1, 1, 2'b00, 9);
    tick();
    chk_wr("pipe_alu", 1, 9, 32'h0000_1111, 2'b00);
    set_pipe(1, 1, 2'b11, 31);
    tick();
    chk_wr("pipe_link", 1, 31, 32'h0000_2222, 2'b11);
    set_pipe(0, 0, 2'b00, 0);
    tick();
    chk_wr("idle", 0, 0, 0, 2'b00);

    // Idle pipeline: mul/div granted immediately.
    set_md(1, 3, 32'h0000_1234);
    chk_comb("md_idle", 1, 0);
    tick();
    chk_wr("md_idle", 1, 3, 32'h0000_1234, 2'b10);
    set_md(0, 0, 0);
    tick();
    chk_wr("md_idle_after", 0, 0, 0, 2'b00);

    // Starvation: four waits, then one forced cycle, then HOLD.
    bus.alu_res = 32'h0000_00A0;
    set_pipe(1, 1, 2'b00, 5);
    set_md(1, 6, 32'h0000_0066);
    for (int i = 0; i < 4; i++) begin
      chk_comb($sformatf("starve_w%0d", i), 0, 0);
      tick();
      chk_wr($sformatf("starve_w%0d", i), 1, 5, 32'h0000_00A0, 2'b00);
    end
    chk_comb("force1", 1, 1);
    tick();
    chk_wr("force1", 1, 6, 32'h0000_0066, 2'b10);
    // A new mul/div result is waiting right away; HOLD must not grant it.
    set_md(1, 8, 32'h0000_0088);
    chk_comb("hold1", 0, 0);
    tick();
    chk_wr("hold1", 1, 5, 32'h0000_00A0, 2'b00);
    bus.alu_res = 32'h0000_00A1;
    for (int i = 0; i < 3; i++) begin
      chk_comb($sformatf("rewait_w%0d", i), 0, 0);
      tick();
      chk_wr($sformatf("rewait_w%0d", i), 1, 5, 32'h0000_00A1, 2'b00);
    end
    chk_comb("force2", 1, 1);
    tick();
    chk_wr("force2", 1, 8, 32'h0000_0088, 2'b10);
    set_md(0, 0, 0);
    chk_comb("hold2", 0, 0);
    tick();
    chk_wr("hold2", 1, 5, 32'h0000_00A1, 2'b00);

    // r0 destination and the illegal source code.
    set_pipe(1, 1, 2'b01, 0);
    tick();
    chk("r0.we", bus.rf_we, 0);
    chk("r0.addr", bus.rf_waddr, 0);
    set_pipe(1, 1, 2'b10, 4);
    tick();
    chk("illegal.we", bus.rf_we, 0);
    chk("illegal.pulse", bus.illegal_src, 1);
    set_pipe(0, 0, 2'b00, 0);
    tick();
    chk("illegal.clear", bus.illegal_src, 0);

    // Early drop in FORCE: no write, back to ARB with a fresh count.
    bus.alu_res = 32'h0000_00B0;
    set_pipe(1, 1, 2'b00, 10);
    set_md(1, 11, 32'h0000_00BB);
    repeat (4) tick();
    set_pipe(0, 0, 2'b00, 0);
    set_md(0, 0, 0);
    chk_comb("drop", 0, 0);
    tick();
    chk("drop.we", bus.rf_we, 0);
    set_pipe(1, 1, 2'b00, 10);
    set_md(1, 12, 32'h0000_00CC);
    for (int i = 0; i < 4; i++) begin
      chk_comb($sformatf("after_drop_w%0d", i), 0, 0);
      tick();
    end
    chk_comb("after_drop_force", 1, 1);
    tick();
    chk_wr("after_drop_force", 1, 12, 32'h0000_00CC, 2'b10);

    // Asynchronous reset while a write is visible and the FSM sits in HOLD.
    set_pipe(0, 0, 2'b00, 0);
    set_md(0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_wr("rst_mid", 0, 0, 0, 2'b00);
    tick();
    rst_n = 1'b1;
    set_md(1, 13, 32'h0000_00DD);
    chk_comb("rst_arb", 1, 0);
    tick();
    chk_wr("rst_arb", 1, 13, 32'h0000_00DD, 2'b10);
    set_md(0, 0, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
